// File: rtl/mpu_sequencer.sv
// Command sequencer for the matrix processing unit: buffers host commands and
// issues them one at a time to the load, multiply and store units.
module mpu_sequencer #(
  parameter int CMD_DEPTH = 4,
  parameter int NUM_REGS  = 8,
  parameter int TIMEOUT   = 1024,
  parameter int RBITS     = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid_in,
  output logic                cmd_ready_out,
  input  logic [1:0]          cmd_op_in,
  input  logic [RBITS-1:0]    cmd_dest_in,
  input  logic [RBITS-1:0]    cmd_src1_in,
  input  logic [RBITS-1:0]    cmd_src2_in,
  output logic                load_en_out,
  output logic [RBITS-1:0]    load_addr_out,
  input  logic                load_done_in,
  output logic                mult_en_out,
  output logic [RBITS-1:0]    mult_src1_out,
  output logic [RBITS-1:0]    mult_src2_out,
  output logic [RBITS-1:0]    mult_dest_out,
  input  logic                mult_done_in,
  output logic                store_en_out,
  output logic [RBITS-1:0]    store_addr_out,
  input  logic                store_done_in,
  output logic [NUM_REGS-1:0] reg_valid_out,
  output logic                busy_out,
  output logic [15:0]         retired_count_out,
  output logic                error_out,
  output logic [1:0]          err_code_out
);

  localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = 2 + 3 * RBITS;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_MULT  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;

  localparam logic [1:0] SEQ_IDLE       = 2'd0;
  localparam logic [1:0] SEQ_WAIT_LOAD  = 2'd1;
  localparam logic [1:0] SEQ_WAIT_MULT  = 2'd2;
  localparam logic [1:0] SEQ_WAIT_STORE = 2'd3;

  localparam logic [1:0] ERR_OPERAND = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  function automatic logic reg_ok(input logic [NUM_REGS-1:0] map,
                                  input logic [RBITS-1:0]    idx);
    reg_ok = map[idx];
  endfunction

  logic [EW-1:0]       fifo_mem_r [CMD_DEPTH];
  logic [PW-1:0]       wr_ptr_r;
  logic [PW-1:0]       rd_ptr_r;
  logic [CW-1:0]       count_r;
  logic [1:0]          state_r;
  logic [TW-1:0]       wait_cnt_r;
  logic [RBITS-1:0]    cmd_dest_r;
  logic                load_en_r;
  logic                mult_en_r;
  logic                store_en_r;
  logic [RBITS-1:0]    load_addr_r;
  logic [RBITS-1:0]    mult_src1_r;
  logic [RBITS-1:0]    mult_src2_r;
  logic [RBITS-1:0]    mult_dest_r;
  logic [RBITS-1:0]    store_addr_r;
  logic [NUM_REGS-1:0] reg_valid_r;
  logic [15:0]         retired_r;
  logic                error_r;
  logic [1:0]          err_code_r;

  logic                full_s;
  logic                push_s;
  logic                pop_s;
  logic                in_wait_s;
  logic [EW-1:0]       head_s;
  logic [1:0]          head_op_s;
  logic [RBITS-1:0]    head_dest_s;
  logic [RBITS-1:0]    head_src1_s;
  logic [RBITS-1:0]    head_src2_s;
  logic                done_s;
  logic                operand_err_s;
  logic                timeout_s;

  assign full_s    = (count_r == CW'(CMD_DEPTH));
  assign push_s    = cmd_valid_in && !full_s;
  assign pop_s     = (state_r == SEQ_IDLE) && (count_r != {CW{1'b0}});
  assign in_wait_s = (state_r != SEQ_IDLE);

  // Decode the FIFO head entry into its fields.
  always_comb begin
    head_s      = fifo_mem_r[rd_ptr_r];
    head_op_s   = head_s[EW-1 -: 2];
    head_dest_s = head_s[3*RBITS-1 -: RBITS];
    head_src1_s = head_s[2*RBITS-1 -: RBITS];
    head_src2_s = head_s[RBITS-1:0];
  end

  // Select the done strobe of the unit being waited on; others are ignored.
  always_comb begin
    done_s = 1'b0;
    case (state_r)
      SEQ_WAIT_LOAD:  done_s = load_done_in;
      SEQ_WAIT_MULT:  done_s = mult_done_in;
      SEQ_WAIT_STORE: done_s = store_done_in;
      default:        done_s = 1'b0;
    endcase
  end

  // Operand check on the popped command: reads of invalid registers are rejected.
  always_comb begin
    operand_err_s = 1'b0;
    if (pop_s) begin
      case (head_op_s)
        OP_MULT:  operand_err_s = !(reg_ok(reg_valid_r, head_src1_s) &&
                                    reg_ok(reg_valid_r, head_src2_s));
        OP_STORE: operand_err_s = !reg_ok(reg_valid_r, head_dest_s);
        default:  operand_err_s = 1'b0;
      endcase
    end else begin
      operand_err_s = 1'b0;
    end
  end

  // The wait counter would reach TIMEOUT-1 at this edge without a done.
  assign timeout_s = in_wait_s && !done_s && (wait_cnt_r == TW'(TIMEOUT - 2));

  // Command FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CMD_DEPTH; i++) begin
        fifo_mem_r[i] <= {EW{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {cmd_op_in, cmd_dest_in, cmd_src1_in, cmd_src2_in};
        wr_ptr_r             <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sequencer FSM: issue, wait for done or timeout, retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= SEQ_IDLE;
      wait_cnt_r   <= {TW{1'b0}};
      cmd_dest_r   <= {RBITS{1'b0}};
      load_en_r    <= 1'b0;
      mult_en_r    <= 1'b0;
      store_en_r   <= 1'b0;
      load_addr_r  <= {RBITS{1'b0}};
      mult_src1_r  <= {RBITS{1'b0}};
      mult_src2_r  <= {RBITS{1'b0}};
      mult_dest_r  <= {RBITS{1'b0}};
      store_addr_r <= {RBITS{1'b0}};
      reg_valid_r  <= {NUM_REGS{1'b0}};
      retired_r    <= 16'd0;
    end else begin
      load_en_r  <= 1'b0;
      mult_en_r  <= 1'b0;
      store_en_r <= 1'b0;
      case (state_r)
        SEQ_IDLE: begin
          if (pop_s) begin
            cmd_dest_r <= head_dest_s;
            wait_cnt_r <= {TW{1'b0}};
            case (head_op_s)
              OP_NOP: retired_r <= retired_r + 16'd1;
              OP_LOAD: begin
                load_en_r   <= 1'b1;
                load_addr_r <= head_dest_s;
                state_r     <= SEQ_WAIT_LOAD;
              end
              OP_MULT: begin
                if (!operand_err_s) begin
                  mult_en_r   <= 1'b1;
                  mult_src1_r <= head_src1_s;
                  mult_src2_r <= head_src2_s;
                  mult_dest_r <= head_dest_s;
                  state_r     <= SEQ_WAIT_MULT;
                end
              end
              OP_STORE: begin
                if (!operand_err_s) begin
                  store_en_r   <= 1'b1;
                  store_addr_r <= head_dest_s;
                  state_r      <= SEQ_WAIT_STORE;
                end
              end
              default: state_r <= SEQ_IDLE;
            endcase
          end
        end
        SEQ_WAIT_LOAD, SEQ_WAIT_MULT, SEQ_WAIT_STORE: begin
          if (done_s) begin
            // Stores read a register; only loads and multiplies produce one.
            if (state_r != SEQ_WAIT_STORE) begin
              reg_valid_r[cmd_dest_r] <= 1'b1;
            end
            retired_r <= retired_r + 16'd1;
            state_r   <= SEQ_IDLE;
          end else if (timeout_s) begin
            state_r <= SEQ_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + TW'(1);
          end
        end
        default: state_r <= SEQ_IDLE;
      endcase
    end
  end

  // Sticky error flag; only the first error code is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_r    <= 1'b0;
      err_code_r <= 2'b00;
    end else if (!error_r && (operand_err_s || timeout_s)) begin
      error_r    <= 1'b1;
      err_code_r <= timeout_s ? ERR_TIMEOUT : ERR_OPERAND;
    end
  end

  assign cmd_ready_out     = !full_s;
  assign busy_out          = (count_r != {CW{1'b0}}) || in_wait_s;
  assign load_en_out       = load_en_r;
  assign load_addr_out     = load_addr_r;
  assign mult_en_out       = mult_en_r;
  assign mult_src1_out     = mult_src1_r;
  assign mult_src2_out     = mult_src2_r;
  assign mult_dest_out     = mult_dest_r;
  assign store_en_out      = store_en_r;
  assign store_addr_out    = store_addr_r;
  assign reg_valid_out     = reg_valid_r;
  assign retired_count_out = retired_r;
  assign error_out         = error_r;
  assign err_code_out      = err_code_r;

endmodule

// File: tb/tb_mpu_sequencer.sv
// Directed self-checking bench for mpu_sequencer (CMD_DEPTH 4, 8 regs, TIMEOUT 16).
module tb_mpu_sequencer;

  localparam logic [1:0] NOP = 2'b00, LOAD = 2'b01, MULT = 2'b10, STORE = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid_in = 1'b0;
  logic       cmd_ready_out;
  logic [1:0] cmd_op_in = 2'b00;
  logic [2:0] cmd_dest_in = 3'd0, cmd_src1_in = 3'd0, cmd_src2_in = 3'd0;
  logic       load_en_out, mult_en_out, store_en_out;
  logic [2:0] load_addr_out, mult_src1_out, mult_src2_out, mult_dest_out, store_addr_out;
  logic       load_done_in = 1'b0, mult_done_in = 1'b0, store_done_in = 1'b0;
  logic [7:0] reg_valid_out;
  logic       busy_out;
  logic [15:0] retired_count_out;
  logic       error_out;
  logic [1:0] err_code_out;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_en [3] = '{0, 0, 0};
  int last_en [3] = '{0, 0, 0};
  int log_q [$];

  mpu_sequencer #(.CMD_DEPTH(4), .NUM_REGS(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .cmd_op_in(cmd_op_in), .cmd_dest_in(cmd_dest_in),
    .cmd_src1_in(cmd_src1_in), .cmd_src2_in(cmd_src2_in),
    .load_en_out(load_en_out), .load_addr_out(load_addr_out), .load_done_in(load_done_in),
    .mult_en_out(mult_en_out), .mult_src1_out(mult_src1_out), .mult_src2_out(mult_src2_out),
    .mult_dest_out(mult_dest_out), .mult_done_in(mult_done_in),
    .store_en_out(store_en_out), .store_addr_out(store_addr_out), .store_done_in(store_done_in),
    .reg_valid_out(reg_valid_out), .busy_out(busy_out),
    .retired_count_out(retired_count_out),
    .error_out(error_out), .err_code_out(err_code_out)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Enable monitor: counts pulses and logs issue order as unit*16 + address.
  always @(negedge clk) begin
    if (rst) begin
      for (int u = 0; u < 3; u++) n_en[u] <= 0;
      log_q.delete();
    end else begin
      if (load_en_out)  begin n_en[0] <= n_en[0] + 1; last_en[0] <= cyc; log_q.push_back(16 + int'(load_addr_out)); end
      if (mult_en_out)  begin n_en[1] <= n_en[1] + 1; last_en[1] <= cyc; log_q.push_back(32 + int'(mult_dest_out)); end
      if (store_en_out) begin n_en[2] <= n_en[2] + 1; last_en[2] <= cyc; log_q.push_back(48 + int'(store_addr_out)); end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_done(input int unit, input logic v);
    case (unit)
      0:       load_done_in = v;
      1:       mult_done_in = v;
      default: store_done_in = v;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid_in = 1'b0;
    load_done_in = 1'b0; mult_done_in = 1'b0; store_done_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [1:0] op, input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
    int budget = 0;
    while (!cmd_ready_out && budget < 50) begin tick(); budget++; end
    check_val("push_ready", cmd_ready_out, 1'b1);
    cmd_op_in = op; cmd_dest_in = d; cmd_src1_in = s1; cmd_src2_in = s2;
    cmd_valid_in = 1'b1;
    tick();
    cmd_valid_in = 1'b0;
  endtask

  // Wait for the nth enable of a unit, then return its done `delay` cycles after it.
  task automatic serve(input int unit, input int nth, input int delay, input string tag);
    int budget = 0;
    while (n_en[unit] < nth && budget < 60) begin tick(); budget++; end
    check_val({tag, "_issue"}, (n_en[unit] >= nth), 1'b1);
    while (cyc < last_en[unit] + delay && budget < 120) begin tick(); budget++; end
    drive_done(unit, 1'b1);
    tick();
    drive_done(unit, 1'b0);
  endtask

  initial begin
    // Reset values, checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    check_val("rst_ready", cmd_ready_out, 1'b1);
    check_val("rst_busy", busy_out, 1'b0);
    check_val("rst_en", {load_en_out, mult_en_out, store_en_out}, 3'b000);
    check_val("rst_addr", {load_addr_out, mult_src1_out, mult_src2_out, mult_dest_out, store_addr_out}, 15'd0);
    check_val("rst_valid", reg_valid_out, 8'h00);
    check_val("rst_retired", retired_count_out, 16'd0);
    check_val("rst_err", {error_out, err_code_out}, 3'b000);
    tick(); tick();
    rst = 1'b0;

    // Basic LOAD, LOAD, MULT, STORE with done 3 cycles after each enable.
    push(LOAD, 3'd0, 3'd0, 3'd0);
    push(LOAD, 3'd1, 3'd0, 3'd0);
    push(MULT, 3'd2, 3'd0, 3'd1);
    push(STORE, 3'd2, 3'd0, 3'd0);
    serve(0, 1, 3, "basic_ld0");
    check_val("basic_en_width", load_en_out, 1'b0);
    serve(0, 2, 3, "basic_ld1");
    serve(1, 1, 3, "basic_mul");
    check_val("basic_mul_addrs", {mult_dest_out, mult_src1_out, mult_src2_out}, {3'd2, 3'd0, 3'd1});
    serve(2, 1, 3, "basic_st");
    tick(); tick();
    check_val("basic_valid", reg_valid_out, 8'h07);
    check_val("basic_retired", retired_count_out, 16'd4);
    check_val("basic_err", error_out, 1'b0);
    check_val("basic_busy", busy_out, 1'b0);
    check_val("basic_store_addr", store_addr_out, 3'd2);
    check_val("basic_log_len", log_q.size(), 4);
    check_val("basic_order0", (log_q.size() > 0) ? log_q[0] : -1, 16);
    check_val("basic_order1", (log_q.size() > 1) ? log_q[1] : -1, 17);
    check_val("basic_order2", (log_q.size() > 2) ? log_q[2] : -1, 34);
    check_val("basic_order3", (log_q.size() > 3) ? log_q[3] : -1, 50);

    // Invalid operands: nothing is issued, first error code is 01.
    do_reset();
    push(MULT, 3'd3, 3'd4, 3'd5);
    push(STORE, 3'd6, 3'd0, 3'd0);
    repeat (6) tick();
    check_val("inv_enables", n_en[0] + n_en[1] + n_en[2], 0);
    check_val("inv_err", {error_out, err_code_out}, 3'b101);
    check_val("inv_retired", retired_count_out, 16'd0);
    check_val("inv_valid", reg_valid_out, 8'h00);
    check_val("inv_busy", busy_out, 1'b0);

    // Timeout after 15 WAIT cycles, then a normal LOAD; error code stays 10.
    do_reset();
    push(LOAD, 3'd1, 3'd0, 3'd0);
    begin
      int budget = 0;
      while (n_en[0] < 1 && budget < 20) begin tick(); budget++; end
      check_val("to_issue", n_en[0], 1);
      while (cyc < last_en[0] + 14 && budget < 60) begin tick(); budget++; end
    end
    check_val("to_pre_err", error_out, 1'b0);
    check_val("to_pre_busy", busy_out, 1'b1);
    tick();
    check_val("to_err", {error_out, err_code_out}, 3'b110);
    check_val("to_idle", busy_out, 1'b0);
    check_val("to_valid", reg_valid_out, 8'h00);
    push(LOAD, 3'd1, 3'd0, 3'd0);
    serve(0, 2, 3, "to_reload");
    tick();
    check_val("to_reload_valid", reg_valid_out, 8'h02);
    check_val("to_reload_retired", retired_count_out, 16'd1);
    check_val("to_code_kept", err_code_out, 2'b10);

    // Backpressure: one in flight plus four queued fills the FIFO.
    do_reset();
    for (int i = 0; i < 5; i++) push(LOAD, 3'(i), 3'd0, 3'd0);
    check_val("bp_full", cmd_ready_out, 1'b0);
    cmd_op_in = LOAD; cmd_dest_in = 3'd5; cmd_valid_in = 1'b1;
    tick();
    check_val("bp_full_hold", cmd_ready_out, 1'b0);
    load_done_in = 1'b1;
    tick();
    load_done_in = 1'b0;
    check_val("bp_ready_before_pop", cmd_ready_out, 1'b0);
    tick();
    check_val("bp_ready_after_pop", cmd_ready_out, 1'b1);
    tick();
    cmd_valid_in = 1'b0;
    check_val("bp_refull", cmd_ready_out, 1'b0);
    for (int k = 2; k <= 6; k++) serve(0, k, 1, "bp_ld");
    tick();
    check_val("bp_valid", reg_valid_out, 8'h3F);
    check_val("bp_retired", retired_count_out, 16'd6);
    check_val("bp_log_len", log_q.size(), 6);
    for (int i = 0; i < 6; i++)
      check_val("bp_order", (i < log_q.size()) ? log_q[i] : -1, 16 + i);

    // Done filtering and single-cycle operation.
    do_reset();
    push(LOAD, 3'd4, 3'd0, 3'd0);
    tick();
    check_val("min_en_latency", load_en_out, 1'b1);
    load_done_in = 1'b1;
    tick();
    load_done_in = 1'b0;
    check_val("min_busy", busy_out, 1'b0);
    check_val("min_valid", reg_valid_out, 8'h10);
    push(LOAD, 3'd3, 3'd0, 3'd0);
    tick(); tick();
    store_done_in = 1'b1; mult_done_in = 1'b1;
    tick();
    store_done_in = 1'b0; mult_done_in = 1'b0;
    tick();
    check_val("flt_busy", busy_out, 1'b1);
    check_val("flt_retired", retired_count_out, 16'd1);
    check_val("flt_valid", reg_valid_out, 8'h10);
    load_done_in = 1'b1;
    tick();
    load_done_in = 1'b0;
    check_val("flt_retire_valid", reg_valid_out, 8'h18);
    check_val("flt_retire_busy", busy_out, 1'b0);
    load_done_in = 1'b1;
    tick();
    load_done_in = 1'b0;
    check_val("flt_idle_done", retired_count_out, 16'd2);
    push(NOP, 3'd0, 3'd0, 3'd0);
    tick();
    check_val("nop_retired", retired_count_out, 16'd3);

    // Asynchronous reset during WAIT_MULT.
    do_reset();
    push(LOAD, 3'd0, 3'd0, 3'd0);
    serve(0, 1, 1, "rm_ld0");
    push(LOAD, 3'd1, 3'd0, 3'd0);
    serve(0, 2, 1, "rm_ld1");
    push(MULT, 3'd2, 3'd0, 3'd1);
    begin
      int budget = 0;
      while (n_en[1] < 1 && budget < 20) begin tick(); budget++; end
    end
    check_val("rm_in_wait", busy_out, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_val("rm_en", {load_en_out, mult_en_out, store_en_out}, 3'b000);
    check_val("rm_addr", {load_addr_out, mult_src1_out, mult_src2_out, mult_dest_out, store_addr_out}, 15'd0);
    check_val("rm_valid", reg_valid_out, 8'h00);
    check_val("rm_retired", retired_count_out, 16'd0);
    check_val("rm_busy", busy_out, 1'b0);
    check_val("rm_ready", cmd_ready_out, 1'b1);
    tick(); tick();
    rst = 1'b0;
    mult_done_in = 1'b1;
    tick();
    mult_done_in = 1'b0;
    tick();
    check_val("rm_post_retired", retired_count_out, 16'd0);
    check_val("rm_post_valid", reg_valid_out, 8'h00);
    check_val("rm_post_busy", busy_out, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mpu_sequencer.md
# mpu_sequencer

Command sequencer for the matrix processing unit. It accepts LOAD / MULT / STORE / NOP commands from the host into a small FIFO and issues them one at a time to the load, multiply and store units. It tracks which matrix registers hold valid data, rejects commands that read invalid registers, and guards every unit operation with a timeout. It sits between the host command interface and the `mpu_load`, `mpu_multiply` and `mpu_store` enables.

## Interface
- `CMD_DEPTH`, default 4: command FIFO entries; power of 2, ≥2.
- `NUM_REGS`, default 8: matrix registers; `RBITS = $clog2(NUM_REGS)`.
- `TIMEOUT`, default 1024: maximum WAIT cycles per operation; ≥2.
- `clk` in 1: clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid_in` in 1: host command valid.
- `cmd_ready_out` out 1: FIFO not full.
- `cmd_op_in` in 2: opcode. 00 = NOP, 01 = LOAD, 10 = MULT, 11 = STORE.
- `cmd_dest_in`, `cmd_src1_in`, `cmd_src2_in` in RBITS each: register addresses.
- `load_en_out` out 1, `load_addr_out` out RBITS, `load_done_in` in 1.
- `mult_en_out` out 1, `mult_src1_out` / `mult_src2_out` / `mult_dest_out` out RBITS each, `mult_done_in` in 1.
- `store_en_out` out 1, `store_addr_out` out RBITS, `store_done_in` in 1.
- `reg_valid_out` out NUM_REGS: per-register valid bitmap.
- `busy_out` out 1: FIFO non-empty or state ≠ IDLE.
- `retired_count_out` out 16: successfully completed commands; wraps at 16 bits.
- `error_out` out 1: sticky error flag.
- `err_code_out` out 2: code of the first error. 01 = invalid operand, 10 = timeout.

## Operation
- **FIFO push:** on `cmd_valid_in & cmd_ready_out`, push {op, dest, src1, src2}.
- **FIFO ready:** `cmd_ready_out = !full`, purely from the registered count. A push and a pop in the same cycle are both honoured.
- **States:** SEQ_IDLE, SEQ_WAIT_LOAD, SEQ_WAIT_MULT, SEQ_WAIT_STORE.
- **IDLE with FIFO non-empty:** pop the head and latch it into a command register, then branch on opcode:
  - NOP: stay in IDLE; `retired_count_out` +1.
  - LOAD: drive `load_en_out` = 1 and `load_addr_out` = dest; go to WAIT_LOAD.
  - MULT:
    - If src1 or src2 is invalid in the bitmap: error code 01, no enable, stay in IDLE.
    - Otherwise: drive `mult_en_out` = 1 with the three address outputs; go to WAIT_MULT.
  - STORE:
    - If dest is invalid: error code 01, no enable, stay in IDLE.
    - Otherwise: drive `store_en_out` = 1 and `store_addr_out` = dest; go to WAIT_STORE.
- **Enables:** registered, high for exactly one cycle. Address outputs hold their value from the enable cycle until retire, then keep their last value.
- **WAIT_x:**
  - The matching `*_done_in` is sampled in every WAIT cycle, including the enable cycle.
  - A done from a non-matching unit, or any done while in IDLE, is ignored.
  - On the matching done: retire. LOAD and MULT set `reg_valid_out[dest]`; `retired_count_out` +1; return to IDLE.
- **Timeout:** the wait counter clears on WAIT entry and increments every WAIT cycle. If it reaches TIMEOUT−1 with no done, record error code 10, leave the bitmap and count unchanged, and return to IDLE.
- **Errors:** `error_out` sets on the first error and stays set until `rst`. `err_code_out` holds the first code; later errors do not overwrite it. After an error, the sequencer continues with the next command.
- **Self-reference:** MULT with dest equal to a source is legal.

## Timing
- **Reset values** (asynchronous, immediate):
  - All `*_en_out` and address outputs = 0.
  - `reg_valid_out` = 0, `retired_count_out` = 0, `error_out` = 0, `err_code_out` = 0, `busy_out` = 0.
  - FIFO empty, so `cmd_ready_out` = 1. State = SEQ_IDLE.
- **Reset mid-operation:** the in-flight command and all queued commands are discarded; units are not notified.
- **Issue latency:** command accepted at edge E0; popped at E1; enable high during the cycle after E1.
- **Retire:** the done sampled at edge Ed returns the state to IDLE after Ed. The next pop occurs at Ed+1, so there is one idle cycle between consecutive operations.
- **Done in the enable cycle:** retire at the next edge (minimum 1-cycle operation).
- **FIFO full:** `cmd_ready_out` = 0 and `cmd_valid_in` is ignored. Ready returns one cycle after a pop.
- **Counter wrap:** 0xFFFF + 1 = 0x0000, with no flag.

## Test plan
- **Basic sequence:** after reset, push LOAD r0, LOAD r1, MULT r2←r0·r1, STORE r2, with each done returned 3 cycles after its enable.
  - Enables appear in that order, each one cycle wide.
  - Final `reg_valid_out` = 0x07, `retired_count_out` = 4, `error_out` = 0.
- **Invalid operands:** from reset, push MULT r3←r4·r5, then STORE r6.
  - No enables issued.
  - `error_out` = 1, `err_code_out` = 01, `retired_count_out` = 0, `reg_valid_out` = 0.
- **Timeout:** with TIMEOUT = 16, push LOAD r1 and never assert `load_done_in`.
  - After 15 WAIT cycles: `error_out` = 1, `err_code_out` = 10, state IDLE.
  - `reg_valid_out[1]` = 0.
  - A following LOAD r1 with a done completes normally; `err_code_out` stays 10.
- **Backpressure:** hold `load_done_in` low; push 6 commands with CMD_DEPTH = 4.
  - Ready drops after the FIFO fills (1 command in flight plus 4 queued).
  - Releasing done pops the head; ready returns one cycle later; no command is lost or duplicated.
- **Reset mid-operation:** assert `rst` asynchronously during WAIT_MULT, mid-cycle.
  - All outputs read 0 before the next edge.
  - `busy_out` = 0; a done pulse after reset release has no effect.
- **Done filtering:** during WAIT_LOAD, pulse `store_done_in` and `mult_done_in`.
  - State is unchanged; only `load_done_in` retires the command.
  - A done arriving in the enable cycle retires the command at the next edge.
